// File: rtl/debug_spram.sv
// Single-port byte-writable RAM with a registered, read-first read path.
// Used as the capture store of the DMA/AXI debug recorder.
module debug_spram #(
    parameter int unsigned ADDR_WIDTH   = 10,
    parameter int unsigned DATA_WIDTH   = 256,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    en_i,
    input  logic [DATA_WIDTH/8-1:0] we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH-1:0]   din_i,
    input  logic                    regce_i,
    input  logic                    sleep_i,
    input  logic                    inject_sbiterr_i,
    input  logic                    inject_dbiterr_i,
    output logic [DATA_WIDTH-1:0]   dout_o,
    output logic                    sbiterr_o,
    output logic                    dbiterr_o
);

    localparam int unsigned NumBytes = DATA_WIDTH / 8;
    localparam int unsigned Depth    = 2 ** ADDR_WIDTH;

    if ((READ_LATENCY != 1) && (READ_LATENCY != 2)) begin : gen_bad_latency
        $error("debug_spram: READ_LATENCY must be 1 or 2");
    end
    if ((DATA_WIDTH % 8) != 0) begin : gen_bad_width
        $error("debug_spram: DATA_WIDTH must be a multiple of 8");
    end

    // Zero-initialised contents; the reset never touches the array.
    logic [DATA_WIDTH-1:0] mem_q [Depth] = '{default: '0};
    logic [DATA_WIDTH-1:0] rd_q;
    logic [DATA_WIDTH-1:0] rd_d;
    logic                  access;

    assign access = en_i & ~sleep_i;

    always_ff @(posedge clk_i) begin
        if (access) begin
            for (int unsigned i = 0; i < NumBytes; i++) begin
                if (we_i[i]) begin
                    mem_q[addr_i][8*i +: 8] <= din_i[8*i +: 8];
                end
            end
        end
    end

    // Non-blocking update above makes this capture the pre-write word.
    always_comb begin
        rd_d = rd_q;
        if (access) begin
            rd_d = mem_q[addr_i];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= '0;
        end else begin
            rd_q <= rd_d;
        end
    end

    if (READ_LATENCY == 2) begin : gen_out_reg
        logic [DATA_WIDTH-1:0] out_q;
        logic [DATA_WIDTH-1:0] out_d;

        always_comb begin
            out_d = out_q;
            if (regce_i && !sleep_i) begin
                out_d = rd_q;
            end
        end

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                out_q <= '0;
            end else begin
                out_q <= out_d;
            end
        end

        assign dout_o = out_q;
    end else begin : gen_no_out_reg
        assign dout_o = rd_q;
    end

    assign sbiterr_o = 1'b0;
    assign dbiterr_o = 1'b0;

    logic unused_ok;
    assign unused_ok = ^{inject_sbiterr_i, inject_dbiterr_i, regce_i};

endmodule

// File: tb/tb_debug_spram.sv
// Scoreboarded random/directed bench for debug_spram, checking a latency-1 and a
// latency-2 instance driven by the same stimulus against an array model.
module tb_debug_spram;

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 256;
    localparam int unsigned NB = DW / 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          en;
    logic [NB-1:0] we;
    logic [AW-1:0] addr;
    logic [DW-1:0] din;
    logic          regce;
    logic          sleep;
    logic          inj_s;
    logic          inj_d;
    logic [DW-1:0] dout1;
    logic [DW-1:0] dout2;
    logic          sbit1, dbit1, sbit2, dbit2;

    always #5 clk = ~clk;

    debug_spram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(1)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .we_i(we), .addr_i(addr), .din_i(din),
        .regce_i(regce), .sleep_i(sleep), .inject_sbiterr_i(inj_s),
        .inject_dbiterr_i(inj_d), .dout_o(dout1), .sbiterr_o(sbit1), .dbiterr_o(dbit1)
    );

    debug_spram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(2)) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .we_i(we), .addr_i(addr), .din_i(din),
        .regce_i(regce), .sleep_i(sleep), .inject_sbiterr_i(inj_s),
        .inject_dbiterr_i(inj_d), .dout_o(dout2), .sbiterr_o(sbit2), .dbiterr_o(dbit2)
    );

    typedef struct {
        int          due;
        bit          load1;
        bit          load2;
        logic [DW-1:0] rdata;
    } item_t;

    item_t         sb_q[$];
    logic [DW-1:0] model_mem [2**AW];
    logic [DW-1:0] exp1 = '0;
    logic [DW-1:0] exp2 = '0;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_err = 0;
    bit            rst_level = 1'b0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    // One access per falling edge; the model computes the read-first word and
    // queues it for the edge that samples these inputs.
    task automatic access(input bit e, input bit slp, input logic [NB-1:0] w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d, input bit rce);
        item_t it;
        @(negedge clk);
        rst_n = rst_level;
        en    = e;
        sleep = slp;
        we    = w;
        addr  = a;
        din   = d;
        regce = rce;
        inj_s = 1'($urandom_range(0, 1));
        inj_d = 1'($urandom_range(0, 1));
        it.due   = cyc + 1;
        it.load1 = e && !slp && rst_level;
        it.load2 = rce && !slp && rst_level;
        it.rdata = model_mem[a];
        if (e && !slp) begin
            for (int b = 0; b < int'(NB); b++) begin
                if (w[b]) model_mem[a][8*b +: 8] = d[8*b +: 8];
            end
        end
        sb_q.push_back(it);
    endtask

    // Called right after access(): lands 3 time units after the next rising edge.
    task automatic async_reset();
        #8;
        rst_level = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("async_reset_dout1", dout1, '0);
        check("async_reset_dout2", dout2, '0);
    endtask

    always @(negedge rst_n) begin
        exp1 = '0;
        exp2 = '0;
    end

    // Monitor: retire scoreboard entries due at this edge, then compare.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
                n_cmp++;
                n_err++;
                $display("FAIL stale_entry: due %0d now %0d", sb_q[0].due, cyc);
                void'(sb_q.pop_front());
            end
            if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
                item_t it;
                it = sb_q.pop_front();
                if (it.load2) exp2 = exp1;
                if (it.load1) exp1 = it.rdata;
            end
            check("dout_lat1", dout1, exp1);
            check("dout_lat2", dout2, exp2);
            check("ecc_flags", DW'({sbit1, dbit1, sbit2, dbit2}), '0);
        end
    end

    function automatic logic [DW-1:0] rand_word();
        logic [DW-1:0] v;
        for (int k = 0; k < int'(DW / 32); k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        logic [AW-1:0] ra;
        logic [NB-1:0] rw;
        int            sel;
        for (int i = 0; i < 2**AW; i++) model_mem[i] = '0;
        rst_n = 1'b0;
        en    = 1'b0;
        sleep = 1'b0;
        we    = '0;
        addr  = '0;
        din   = '0;
        regce = 1'b0;
        inj_s = 1'b0;
        inj_d = 1'b0;

        access(1'b1, 1'b0, '0, 10'd4, '0, 1'b1);
        access(1'b0, 1'b0, '0, 10'd0, '0, 1'b0);
        rst_level = 1'b1;

        // Power-up reads
        access(1'b1, 1'b0, '0, 10'd5, '0, 1'b1);
        access(1'b1, 1'b0, '0, 10'd0, '0, 1'b1);
        access(1'b1, 1'b0, '0, 10'd1023, '0, 1'b1);
        // Full write, read back, then masked write with read-first
        access(1'b1, 1'b0, '1, 10'd3, {32{8'hA5}}, 1'b1);
        access(1'b1, 1'b0, '0, 10'd3, '0, 1'b1);
        access(1'b1, 1'b0, 32'h1F, 10'd3, {32{8'h11}}, 1'b1);
        access(1'b1, 1'b0, '0, 10'd3, '0, 1'b1);
        // Disabled cycles with moving address, then a slept write
        access(1'b0, 1'b0, '1, 10'd10, rand_word(), 1'b1);
        access(1'b0, 1'b0, '0, 10'd20, rand_word(), 1'b1);
        access(1'b0, 1'b0, '0, 10'd30, rand_word(), 1'b1);
        access(1'b1, 1'b1, '1, 10'd7, rand_word(), 1'b1);
        access(1'b1, 1'b0, '0, 10'd7, '0, 1'b1);
        // Output-stage enable gating
        access(1'b1, 1'b0, '0, 10'd3, '0, 1'b0);
        access(1'b1, 1'b0, '0, 10'd5, '0, 1'b0);
        access(1'b0, 1'b0, '0, 10'd0, '0, 1'b1);
        access(1'b0, 1'b0, '0, 10'd0, '0, 1'b1);
        // Mid-cycle reset; writes during reset still land
        access(1'b1, 1'b0, '0, 10'd3, '0, 1'b1);
        async_reset();
        access(1'b1, 1'b0, '1, 10'd9, rand_word(), 1'b1);
        access(1'b1, 1'b0, '0, 10'd3, '0, 1'b1);
        rst_level = 1'b1;
        access(1'b1, 1'b0, '0, 10'd9, '0, 1'b1);
        access(1'b1, 1'b0, '0, 10'd3, '0, 1'b1);
        access(1'b0, 1'b0, '0, 10'd0, '0, 1'b1);

        // Random traffic on a small address pool at both ends to force collisions
        repeat (1500) begin
            ra  = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 7))
                                              : AW'(1016 + $urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            rw  = (sel < 3) ? '0 : (sel < 5) ? '1 : NB'($urandom);
            access(($urandom_range(0, 9) < 8), ($urandom_range(0, 9) == 0), rw, ra,
                   rand_word(), ($urandom_range(0, 9) < 7));
        end

        access(1'b0, 1'b0, '0, 10'd0, '0, 1'b0);
        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
